enemy_sequencer: RTL and testbench

Control FSM that drives one enemy datapath through its frame loop: clear timers, draw sprite, wait one frame period, erase sprite, step position, repeat. It generates the datapath strobes (reset_C, enable_delay, enable_XY, erase, plot) from the datapath's hold/done handshakes and produces the VGA write enable. It also provides pause, a graceful stop, a plot watchdog and a move counter for the game-level controller.

---
 rtl/enemy_sequencer.sv | 109 ++++++++++
 tb/tb_enemy_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_sequencer.sv
// enemy_sequencer: frame-loop controller for one enemy sprite datapath.
// Loop: CLEAR -> PRE_DRAW -> DRAW -> WAIT -> PRE_ERASE -> ERASE -> MOVE -> CLEAR.
// Ports: clk/reset_N (sync, active-low); start/stop/pause level controls;
//   hold/done datapath handshakes; reset_C/enable_delay/enable_XY/erase/plot
//   datapath strobes; vga_we pixel write enable; busy/timeout_err/move_count/
//   state_dbg status for the game-level controller.
module enemy_sequencer #(
  parameter int PLOT_TIMEOUT = 255,
  parameter int MOVE_W       = 8
) (
  input  logic              clk,
  input  logic              reset_N,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              hold,
  input  logic              done,
  output logic              reset_C,
  output logic              enable_delay,
  output logic              enable_XY,
  output logic              erase,
  output logic              plot,
  output logic              vga_we,
  output logic              busy,
  output logic              timeout_err,
  output logic [MOVE_W-1:0] move_count,
  output logic [2:0]        state_dbg
);

  localparam int WD_W = $clog2(PLOT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    PRE_DRAW  = 3'd2,
    DRAW      = 3'd3,
    WAIT      = 3'd4,
    PRE_ERASE = 3'd5,
    ERASE     = 3'd6,
    MOVE      = 3'd7
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WD_W-1:0] wdog;
  logic            wd_exp;
  logic            in_wait;
  logic            plotting;

  // Abort fires on the PLOT_TIMEOUT-th cycle of DRAW/ERASE; a done arriving
  // in that same cycle takes priority and suppresses the error.
  assign plotting = (state == DRAW) || (state == ERASE);
  assign wd_exp   = plotting && (wdog == WD_W'(PLOT_TIMEOUT - 1)) && !done;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (start) state_nxt = CLEAR;
      CLEAR:     state_nxt = PRE_DRAW;
      PRE_DRAW:  state_nxt = DRAW;
      DRAW:      if (done || wd_exp) state_nxt = WAIT;
      WAIT:      if (hold) state_nxt = PRE_ERASE;
      PRE_ERASE: state_nxt = ERASE;
      ERASE:     if (done || wd_exp) state_nxt = stop ? IDLE : MOVE;
      MOVE:      state_nxt = CLEAR;
      default:   state_nxt = IDLE;
    endcase
  end

  // State and strobes registered together; strobes are decoded from the
  // state being entered so they line up with state_dbg.
  always_ff @(posedge clk) begin
    if (!reset_N) begin
      state       <= IDLE;
      reset_C     <= 1'b1;
      enable_XY   <= 1'b0;
      erase       <= 1'b0;
      plot        <= 1'b0;
      busy        <= 1'b0;
      in_wait     <= 1'b0;
      wdog        <= '0;
      timeout_err <= 1'b0;
      move_count  <= '0;
    end else begin
      state     <= state_nxt;
      reset_C   <= (state_nxt != CLEAR);
      enable_XY <= (state_nxt == MOVE);
      erase     <= (state_nxt == PRE_ERASE) || (state_nxt == ERASE);
      plot      <= (state_nxt == DRAW) || (state_nxt == ERASE);
      busy      <= (state_nxt != IDLE);
      in_wait   <= (state_nxt == WAIT);

      // PRE_DRAW/PRE_ERASE always precede the plot states, so any non-plot
      // cycle clearing the counter gives a clean start on entry.
      if (plotting) wdog <= wdog + WD_W'(1);
      else          wdog <= '0;

      if (wd_exp) timeout_err <= 1'b1;

      if (state == MOVE) move_count <= move_count + MOVE_W'(1);
    end
  end

  // Pause only gates the frame delay counter; hold still advances WAIT.
  assign enable_delay = in_wait & ~pause;
  assign vga_we       = plot & ~done;
  assign state_dbg    = state;

endmodule

// File: tb/tb_enemy_sequencer.sv
// Testbench for enemy_sequencer: directed loop scenarios plus randomized
// traffic, every cycle compared against a phase/duration reference model.
module tb_enemy_sequencer;

  localparam int PT = 255;
  localparam int MW = 2;

  localparam int P_IDLE = 0, P_CLEAR = 1, P_PRE_DRAW = 2, P_DRAW = 3;
  localparam int P_WAIT = 4, P_PRE_ERASE = 5, P_ERASE = 6, P_MOVE = 7;

  logic          clk = 1'b0;
  logic          reset_N, start, stop, pause, hold, done;
  logic          reset_C, enable_delay, enable_XY, erase, plot, vga_we;
  logic          busy, timeout_err;
  logic [MW-1:0] move_count;
  logic [2:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  // reference model: current phase, 1-based cycle index within it
  int m_ph, m_cnt, m_moves;
  bit m_err;

  // stimulus knobs
  int draw_len, wait_len, erase_len, stop_pct, pause_mode;
  bit start_lvl, noise, rst_req, rst_in_erase;

  enemy_sequencer #(.PLOT_TIMEOUT(PT), .MOVE_W(MW)) dut (
    .clk(clk), .reset_N(reset_N), .start(start), .stop(stop), .pause(pause),
    .hold(hold), .done(done), .reset_C(reset_C), .enable_delay(enable_delay),
    .enable_XY(enable_XY), .erase(erase), .plot(plot), .vga_we(vga_we),
    .busy(busy), .timeout_err(timeout_err), .move_count(move_count),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, want, $time);
    end
  endtask

  // One clock of the spec's loop, using the inputs present at the edge.
  function automatic void model_step();
    int nxt;
    bit finish;
    if (!reset_N) begin
      m_ph = P_IDLE; m_cnt = 1; m_err = 0; m_moves = 0;
      return;
    end
    nxt = m_ph;
    finish = done || (m_cnt == PT);
    case (m_ph)
      P_IDLE:      if (start) nxt = P_CLEAR;
      P_CLEAR:     nxt = P_PRE_DRAW;
      P_PRE_DRAW:  nxt = P_DRAW;
      P_DRAW:      if (finish) nxt = P_WAIT;
      P_WAIT:      if (hold) nxt = P_PRE_ERASE;
      P_PRE_ERASE: nxt = P_ERASE;
      P_ERASE:     if (finish) nxt = stop ? P_IDLE : P_MOVE;
      default:     begin nxt = P_CLEAR; m_moves++; end
    endcase
    if ((m_ph == P_DRAW || m_ph == P_ERASE) && !done && m_cnt == PT) m_err = 1;
    m_cnt = (nxt == m_ph) ? m_cnt + 1 : 1;
    m_ph = nxt;
  endfunction

  task automatic drive_inputs();
    done  = (m_ph == P_DRAW && m_cnt > draw_len) || (m_ph == P_ERASE && m_cnt > erase_len);
    hold  = (m_ph == P_WAIT && m_cnt > wait_len);
    if (noise) begin
      if (m_ph != P_DRAW && m_ph != P_ERASE) done = 1'($urandom_range(0, 1));
      if (m_ph != P_WAIT) hold = 1'($urandom_range(0, 1));
    end
    case (pause_mode)
      1:       pause = 1'($urandom_range(0, 1));
      2:       pause = (m_ph == P_WAIT && m_cnt >= wait_len - 8 && m_cnt <= wait_len + 1);
      default: pause = 1'b0;
    endcase
    stop  = ($urandom_range(0, 99) < stop_pct);
    start = start_lvl;
    reset_N = !rst_req;
    if (rst_in_erase && m_ph == P_ERASE && m_cnt == 3) begin
      reset_N = 1'b0;
      rst_in_erase = 0;
    end
  endtask

  task automatic check_outputs();
    chk("state", state_dbg, m_ph);
    chk("busy", busy, m_ph != P_IDLE);
    chk("reset_C", reset_C, m_ph != P_CLEAR);
    chk("plot", plot, m_ph == P_DRAW || m_ph == P_ERASE);
    chk("erase", erase, m_ph == P_PRE_ERASE || m_ph == P_ERASE);
    chk("enable_XY", enable_XY, m_ph == P_MOVE);
    chk("vga_we", vga_we, (m_ph == P_DRAW || m_ph == P_ERASE) && !done);
    chk("enable_delay", enable_delay, m_ph == P_WAIT && !pause);
    chk("timeout_err", timeout_err, m_err);
    chk("move_count", move_count, m_moves % (1 << MW));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    drive_inputs();
    #1;
    check_outputs();
  endtask

  task automatic set_lens(input int d, input int w, input int e);
    draw_len = d; wait_len = w; erase_len = e;
  endtask

  initial begin
    int n, tgt, mc0, xy;
    start_lvl = 0; noise = 0; stop_pct = 0; pause_mode = 0; rst_in_erase = 0;
    rst_req = 1;
    set_lens(100, 20, 100);
    m_ph = P_IDLE; m_cnt = 1; m_err = 0; m_moves = 0;
    reset_N = 0; start = 1; stop = 0; pause = 0; hold = 0; done = 0;
    tick();
    tick();
    rst_req = 0;
    start_lvl = 1;

    // first loop: 100 write cycles in DRAW, one move at the end
    n = 0;
    for (int i = 0; i < 600 && m_moves == 0; i++) begin
      tick();
      if (state_dbg == 3'(P_DRAW) && vga_we === 1'b1) n++;
    end
    chk("loop1_moves", move_count, 1);
    chk("draw_we_cycles", n, 100);

    // done coincident with the final watchdog cycle: no error
    set_lens(PT - 1, 2, PT - 1);
    tgt = m_moves + 1;
    for (int i = 0; i < 1200 && m_moves < tgt; i++) tick();
    chk("done_wins_err", timeout_err, 0);

    // pause window in WAIT, hold arriving while still paused
    set_lens(5, 20, 5);
    pause_mode = 2;
    n = 0;
    tgt = m_moves + 1;
    for (int i = 0; i < 200 && m_moves < tgt; i++) begin
      tick();
      if (state_dbg == 3'(P_WAIT) && enable_delay === 1'b0) n++;
    end
    chk("pause_cycles", n, 10);
    pause_mode = 0;

    // DRAW watchdog abort
    set_lens(1000, 3, 5);
    n = 0;
    tgt = m_moves + 1;
    for (int i = 0; i < 600 && m_moves < tgt; i++) begin
      tick();
      if (state_dbg == 3'(P_DRAW)) n++;
    end
    chk("draw_timeout_len", n, PT);
    chk("timeout_set", timeout_err, 1);

    // ERASE watchdog abort, error stays sticky
    set_lens(4, 3, 1000);
    tgt = m_moves + 1;
    for (int i = 0; i < 600 && m_moves < tgt; i++) tick();
    set_lens(4, 3, 4);
    tgt = m_moves + 1;
    for (int i = 0; i < 100 && m_moves < tgt; i++) tick();
    chk("timeout_sticky", timeout_err, 1);

    // stop at ERASE exit
    start_lvl = 0;
    stop_pct = 100;
    mc0 = int'(move_count);
    xy = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (enable_XY === 1'b1) xy++;
      if (m_ph == P_IDLE) break;
    end
    chk("stop_idle", state_dbg, P_IDLE);
    chk("stop_busy", busy, 0);
    chk("stop_no_move", xy, 0);
    chk("stop_count_kept", move_count, mc0);
    stop_pct = 0;

    // reset in the middle of ERASE
    start_lvl = 1;
    rst_in_erase = 1;
    for (int i = 0; i < 100 && rst_in_erase; i++) tick();
    tick();
    chk("rst_state", state_dbg, P_IDLE);
    chk("rst_moves", move_count, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_plot", plot, 0);

    // move_count wrap: 1,2,3,0,1
    set_lens(3, 2, 3);
    for (int k = 1; k <= 5; k++) begin
      for (int i = 0; i < 100 && m_moves < k; i++) tick();
      chk("wrap_count", move_count, k % 4);
    end

    // randomized traffic
    noise = 1;
    pause_mode = 1;
    stop_pct = 10;
    for (int i = 0; i < 6000; i++) begin
      if (i % 40 == 0) begin
        set_lens($urandom_range(0, 300), $urandom_range(0, 10), $urandom_range(0, 300));
        start_lvl = 1'($urandom_range(0, 3) != 0);
        rst_req = ($urandom_range(0, 99) < 3);
      end else begin
        rst_req = 0;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
